axi_data_mem_bridge: RTL and testbench
======================================

Name: axi_data_mem_bridge

Overview:
AXI4 slave that terminates the GPU's AXI4 data master port and turns each burst into single-word requests on the simple valid/ready data-memory interface (data_mem_read_*/data_mem_write_*). It sits directly downstream of the GPU top-level AXI master, between it and the data memory model or BRAM.
It serves one transaction at a time and supports FIXED and INCR bursts. A round-robin arbiter chooses between a pending read and a pending write.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI address width (byte address)
C_S_AXI_DATA_WIDTH, 32, AXI data width; equals the memory word width
C_S_AXI_ID_WIDTH, 1, AXI ID width
MEM_ADDR_WIDTH, 32, word-address width on the memory side

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID/ADDR/8/3/2/1  write-address channel
s_axi_awready  out  1  write-address accept
s_axi_wdata/wstrb/wlast/wvalid  in  DATA/DATA/8/1/1  write-data channel
s_axi_wready  out  1  write-data accept
s_axi_bid/bresp/bvalid  out  ID/2/1  write response
s_axi_bready  in  1  write-response accept
s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID/ADDR/8/3/2/1  read-address channel
s_axi_arready  out  1  read-address accept
s_axi_rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1  read-data channel
s_axi_rready  in  1  read-data accept
mem_read_valid  out  1  memory read request
mem_read_address  out  MEM_ADDR_WIDTH  word address
mem_read_ready  in  1  one-cycle pulse; mem_read_data is valid in the same cycle
mem_read_data  in  DATA  read word
mem_write_valid  out  1  memory write request
mem_write_address  out  MEM_ADDR_WIDTH  word address
mem_write_data  out  DATA  write word
mem_write_ready  in  1  one-cycle write-accept pulse

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values: all valids and readys 0; bresp, rresp, rdata, rid, bid and the memory addresses/data all 0; state IDLE; arbiter priority = read.
- Reset mid-operation: the in-flight burst is abandoned with no response. The outputs take their reset values at the first clock edge where reset is sampled high.
- States: IDLE, RD_MEM, RD_BEAT, WR_BEAT, WR_MEM, WR_RESP.

IDLE and arbitration:
- In IDLE, s_axi_arready = arvalid && (!awvalid || prio==read) and s_axi_awready = awvalid && (!arvalid || prio==write). Both are combinational and are 0 in every other state.
- On a handshake, capture id, len and burst, plus word address = addr >> log2(DATA/8), truncated to MEM_ADDR_WIDTH. Also capture an error flag.
- The error flag is set when size != log2(DATA/8) or burst is neither FIXED (00) nor INCR (01).
- After each grant, prio flips to the other direction.

Read path:
- AR handshake moves the FSM to RD_MEM, or straight to RD_BEAT if the error flag is set.
- RD_MEM: mem_read_valid=1 with a stable address. On mem_read_ready, latch the data and go to RD_BEAT.
- RD_BEAT: rvalid=1, rid=captured id, rresp=00 (or 10 SLVERR with rdata=0 on error), rlast=(beat==len).
- On rvalid && rready: if this is the last beat, return to IDLE; otherwise advance the address (INCR: +1 with wrap modulo 2^MEM_ADDR_WIDTH; FIXED: unchanged) and go back to RD_MEM (or RD_BEAT on error).
- Zero-wait read latency: AR handshake at cycle T gives mem_read_valid at T+1 and rvalid at T+2.

Write path:
- AW handshake moves the FSM to WR_BEAT.
- WR_BEAT: wready=1. On a W handshake, latch wdata.
- Go to WR_MEM, unless the error flag is set or wstrb==0; in those cases skip the memory access and go to WR_RESP if this is the last beat, else stay in WR_BEAT with the address advanced.
- Partial wstrb still writes the full word.
- WR_MEM: mem_write_valid=1. On mem_write_ready, go to WR_RESP if this is the last beat, else advance the address and go to WR_BEAT.
- The beat count is set by awlen. If wlast is seen on any beat other than the last, or is absent on the last beat, the error flag is set (the remaining writes are still performed) and bresp=10.
- WR_RESP: bvalid=1, bid=captured id, bresp=00 or 10. Hold until bready, then go to IDLE.

Handshake rule:
- Every valid output is held, with its payload stable, until the matching ready; valid is never withdrawn early.

Test Plan:
- Single read: araddr=0x10, arlen=0, arsize=2, arburst=01; memory word 4 = 0xDEADBEEF, zero-wait -> mem_read_address=4; one beat rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid; rvalid at T+2.
- INCR write burst: awaddr=0x20, awlen=3; wdata 1,2,3,4; mem_write_ready delayed 2 cycles per beat -> writes to words 8,9,10,11 in order; mem_write_valid held through the wait; one bvalid with bresp=00.
- Simultaneous arvalid and awvalid after reset -> read granted first; the write is granted after the read burst; with both channels continuously pending, grants alternate R, W, R.
- Error and FIXED cases: arsize=1 -> no mem_read_valid, arlen+1 beats with rresp=10 and rdata=0. arburst=00 with arlen=2 -> three reads, all from the same word.
- wlast asserted on beat 1 of an awlen=2 burst -> all 3 memory writes still performed; bresp=10.
- Backpressure and reset: rready held low for 5 cycles -> rvalid, rdata and rlast stable throughout. reset asserted during RD_MEM -> after the next edge, all outputs are 0, the FSM is in IDLE, and a new AR is accepted normally.

Source files
------------

// File: rtl/axi_data_mem_bridge.sv
// Purpose: AXI4 slave bridge. Each FIXED/INCR burst becomes one single-word request per beat
//          on a simple valid/ready data-memory port. One transaction is in flight at a time.
// Latency: AR handshake at cycle T gives mem_read_valid at T+1 and, with a zero-wait memory,
//          rvalid at T+2. Each write beat costs one W cycle plus one memory cycle.
// Backpressure: every valid (rvalid, bvalid, mem_*_valid) holds with a stable payload until its
//          ready. AR/AW are accepted only in IDLE. W is accepted only while waiting for a beat.
// Ports:
//   clk, reset       - single clock domain, synchronous active-high reset
//   s_axi_aw*/w*/b*  - AXI4 write address, data and response channels
//   s_axi_ar*/r*     - AXI4 read address and data channels
//   mem_read_*       - word-addressed read request. ready is a one-cycle pulse with data
//   mem_write_*      - word-addressed write request. ready is a one-cycle accept pulse
module axi_data_mem_bridge #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int MEM_ADDR_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  // write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  // write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  // read data channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  // memory read port
  output logic                            mem_read_valid,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_read_address,
  input  logic                            mem_read_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_read_data,
  // memory write port
  output logic                            mem_write_valid,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_write_address,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_write_data,
  input  logic                            mem_write_ready
);

  // Byte-to-word shift and the only AXI size this bridge serves (full-width beats).
  localparam int         BYTE_SHIFT = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam logic [2:0] AXI_SIZE   = 3'(BYTE_SHIFT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_MEM  = 3'd1;
  localparam logic [2:0] ST_RD_BEAT = 3'd2;
  localparam logic [2:0] ST_WR_BEAT = 3'd3;
  localparam logic [2:0] ST_WR_MEM  = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;

  logic [2:0]                      r_state;
  logic                            r_prio_wr;    // 0: read wins a tie, 1: write wins
  logic [C_S_AXI_ID_WIDTH-1:0]     r_id;
  logic [7:0]                      r_len;
  logic [7:0]                      r_beat;
  logic                            r_incr;
  logic                            r_err;        // bad size/burst: no memory access, SLVERR
  logic                            r_wlast_err;  // misplaced wlast: writes proceed, SLVERR
  logic [MEM_ADDR_WIDTH-1:0]       r_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;

  logic                            w_idle;
  logic                            w_ar_grant;
  logic                            w_aw_grant;
  logic                            w_ar_err;
  logic                            w_aw_err;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_ar_shift;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_aw_shift;
  logic [MEM_ADDR_WIDTH-1:0]       w_ar_word;
  logic [MEM_ADDR_WIDTH-1:0]       w_aw_word;
  logic                            w_last_beat;
  logic [MEM_ADDR_WIDTH-1:0]       w_next_addr;
  logic                            w_skip_mem;

  // Round-robin between the two address channels. Only one grant can be issued per cycle.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_ar_grant = w_idle && s_axi_arvalid && (!s_axi_awvalid || !r_prio_wr);
  assign w_aw_grant = w_idle && s_axi_awvalid && (!s_axi_arvalid || r_prio_wr);

  assign w_ar_err   = (s_axi_arsize != AXI_SIZE) || s_axi_arburst[1];
  assign w_aw_err   = (s_axi_awsize != AXI_SIZE) || s_axi_awburst[1];

  assign w_ar_shift = s_axi_araddr >> BYTE_SHIFT;
  assign w_aw_shift = s_axi_awaddr >> BYTE_SHIFT;
  assign w_ar_word  = MEM_ADDR_WIDTH'(w_ar_shift);
  assign w_aw_word  = MEM_ADDR_WIDTH'(w_aw_shift);

  assign w_last_beat = (r_beat == r_len);
  // INCR wraps naturally at 2^MEM_ADDR_WIDTH. FIXED re-uses the same word every beat.
  assign w_next_addr = r_incr ? (r_addr + MEM_ADDR_WIDTH'(1)) : r_addr;
  // A beat with no strobes, or any beat of a malformed burst, never reaches memory.
  assign w_skip_mem  = r_err || (s_axi_wstrb == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prio_wr   <= 1'b0;
      r_id        <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_incr      <= 1'b0;
      r_err       <= 1'b0;
      r_wlast_err <= 1'b0;
      r_addr      <= '0;
      r_rdata     <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_grant) begin
            r_id        <= s_axi_arid;
            r_len       <= s_axi_arlen;
            r_beat      <= '0;
            r_incr      <= (s_axi_arburst == BURST_INCR);
            r_err       <= w_ar_err;
            r_wlast_err <= 1'b0;
            r_addr      <= w_ar_word;
            r_prio_wr   <= 1'b1;
            r_state     <= w_ar_err ? ST_RD_BEAT : ST_RD_MEM;
          end else if (w_aw_grant) begin
            r_id        <= s_axi_awid;
            r_len       <= s_axi_awlen;
            r_beat      <= '0;
            r_incr      <= (s_axi_awburst == BURST_INCR);
            r_err       <= w_aw_err;
            r_wlast_err <= 1'b0;
            r_addr      <= w_aw_word;
            r_prio_wr   <= 1'b0;
            r_state     <= ST_WR_BEAT;
          end
        end

        ST_RD_MEM: begin
          if (mem_read_ready) begin
            r_rdata <= mem_read_data;
            r_state <= ST_RD_BEAT;
          end
        end

        ST_RD_BEAT: begin
          if (s_axi_rready) begin
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= w_next_addr;
              r_state <= r_err ? ST_RD_BEAT : ST_RD_MEM;
            end
          end
        end

        ST_WR_BEAT: begin
          if (s_axi_wvalid) begin
            r_wdata <= s_axi_wdata;
            // The beat count comes from awlen. wlast is only checked for consistency.
            if (s_axi_wlast != w_last_beat) begin
              r_wlast_err <= 1'b1;
            end
            if (w_skip_mem) begin
              if (w_last_beat) begin
                r_state <= ST_WR_RESP;
              end else begin
                r_beat <= r_beat + 8'd1;
                r_addr <= w_next_addr;
              end
            end else begin
              r_state <= ST_WR_MEM;
            end
          end
        end

        ST_WR_MEM: begin
          if (mem_write_ready) begin
            if (w_last_beat) begin
              r_state <= ST_WR_RESP;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= w_next_addr;
              r_state <= ST_WR_BEAT;
            end
          end
        end

        ST_WR_RESP: begin
          if (s_axi_bready) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_arready = w_ar_grant;
  assign s_axi_awready = w_aw_grant;
  assign s_axi_wready  = (r_state == ST_WR_BEAT);

  // Read data channel. Error beats return zero data so stale words never leak out.
  assign s_axi_rvalid = (r_state == ST_RD_BEAT);
  assign s_axi_rid    = r_id;
  assign s_axi_rdata  = r_err ? '0 : r_rdata;
  assign s_axi_rresp  = (s_axi_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rlast  = s_axi_rvalid && w_last_beat;

  // Write response channel
  assign s_axi_bvalid = (r_state == ST_WR_RESP);
  assign s_axi_bid    = r_id;
  assign s_axi_bresp  = (s_axi_bvalid && (r_err || r_wlast_err)) ? RESP_SLVERR : RESP_OKAY;

  // Memory ports. The address and data come straight from registers, so they stay stable while valid.
  assign mem_read_valid    = (r_state == ST_RD_MEM);
  assign mem_read_address  = r_addr;
  assign mem_write_valid   = (r_state == ST_WR_MEM);
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_wdata;

endmodule

// File: tb/tb_axi_data_mem_bridge.sv
module tb_axi_data_mem_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_awid, s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arid, s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [31:0] mem_read_address, mem_read_data, mem_write_address, mem_write_data;

  always #5 clk = ~clk;

  axi_data_mem_bridge dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
  } rbeat_t;
  typedef struct packed {
    logic [1:0] resp;
    logic       id;
  } bresp_t;

  logic [31:0] mem_arr [logic [31:0]];
  rbeat_t      exp_r[$];
  logic [31:0] exp_ra[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  bresp_t      exp_b[$];

  // observation logs used for the hand-computed checks
  logic        glog[$];       // 0 = read grant, 1 = write grant
  logic [31:0] rdlog[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [31:0] rlog_d[$];
  logic [1:0]  rlog_resp[$];
  logic [1:0]  last_bresp;
  int          t_ar, t_mrv, t_rv;
  logic        model_prio_wr = 1'b0;

  int rd_delay = 0;
  int wr_delay = 0;
  int rr_mode = 1;            // 0 random rready, 1 always ready, 2 held low

  logic [31:0] tx_wd[16];
  logic [3:0]  tx_ws[16];
  logic        tx_wl[16];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int rd_cnt, wr_cnt;
    rd_cnt = 0;
    wr_cnt = 0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
      if (reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (mem_read_valid) begin
          if (rd_cnt >= rd_delay) begin
            mem_read_ready = 1'b1;
            mem_read_data = mem_rd(mem_read_address);
            rd_cnt = 0;
          end else rd_cnt++;
        end
        if (mem_write_valid) begin
          if (wr_cnt >= wr_delay) begin
            mem_write_ready = 1'b1;
            mem_arr[mem_write_address] = mem_write_data;
            wr_cnt = 0;
          end else wr_cnt++;
        end
      end
    end
  end

  // ---------------- response-channel readiness ----------------
  initial begin
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0: s_axi_rready = ($urandom_range(0, 3) != 0);
        1: s_axi_rready = 1'b1;
        default: s_axi_rready = 1'b0;
      endcase
      s_axi_bready = (rr_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic        p_rv, p_rr, p_mrv, p_mrr, p_mwv, p_mwr, p_bv, p_br, p_rlast;
    logic [31:0] p_rdata, p_mra, p_mwa, p_mwd;
    logic [1:0]  p_rresp, p_bresp;
    rbeat_t      e;
    bresp_t      eb;
    p_rv = 0; p_rr = 0; p_mrv = 0; p_mrr = 0; p_mwv = 0; p_mwr = 0; p_bv = 0; p_br = 0;
    p_rlast = 0; p_rdata = 0; p_mra = 0; p_mwa = 0; p_mwd = 0; p_rresp = 0; p_bresp = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        p_rv = 0; p_mrv = 0; p_mwv = 0; p_bv = 0;
        model_prio_wr = 1'b0;
        continue;
      end
      // a valid left waiting must still be there with the same payload
      if (p_rv && !p_rr) begin
        chk("r_hold_valid", s_axi_rvalid, 1'b1);
        chk("r_hold_data", s_axi_rdata, p_rdata);
        chk("r_hold_last", s_axi_rlast, p_rlast);
        chk("r_hold_resp", s_axi_rresp, p_rresp);
      end
      if (p_mrv && !p_mrr) begin
        chk("mrd_hold_valid", mem_read_valid, 1'b1);
        chk("mrd_hold_addr", mem_read_address, p_mra);
      end
      if (p_mwv && !p_mwr) begin
        chk("mwr_hold_valid", mem_write_valid, 1'b1);
        chk("mwr_hold_addr", mem_write_address, p_mwa);
        chk("mwr_hold_data", mem_write_data, p_mwd);
      end
      if (p_bv && !p_br) begin
        chk("b_hold_valid", s_axi_bvalid, 1'b1);
        chk("b_hold_resp", s_axi_bresp, p_bresp);
      end
      // arbitration: on a tie the favoured direction is the opposite of the last grant
      if (s_axi_arvalid && s_axi_awvalid && (s_axi_arready || s_axi_awready))
        chk("arb_winner", {s_axi_arready, s_axi_awready}, model_prio_wr ? 2'b01 : 2'b10);
      if (s_axi_arvalid && s_axi_arready) begin
        glog.push_back(1'b0);
        t_ar = cyc;
        model_prio_wr = 1'b1;
      end else if (s_axi_awvalid && s_axi_awready) begin
        glog.push_back(1'b1);
        model_prio_wr = 1'b0;
      end
      if (mem_read_valid && !p_mrv) t_mrv = cyc;
      if (s_axi_rvalid && !p_rv) t_rv = cyc;
      if (mem_read_valid && mem_read_ready) begin
        rdlog.push_back(mem_read_address);
        if (exp_ra.size() == 0) chk("mem_rd_unexpected", mem_read_address, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mem_rd_addr", mem_read_address, exp_ra.pop_front());
      end
      if (mem_write_valid && mem_write_ready) begin
        wlog_a.push_back(mem_write_address);
        wlog_d.push_back(mem_write_data);
        if (exp_wa.size() == 0) chk("mem_wr_unexpected", mem_write_address, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("mem_wr_addr", mem_write_address, exp_wa.pop_front());
          chk("mem_wr_data", mem_write_data, exp_wd.pop_front());
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        rlog_d.push_back(s_axi_rdata);
        rlog_resp.push_back(s_axi_rresp);
        if (exp_r.size() == 0) chk("r_unexpected", s_axi_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = exp_r.pop_front();
          chk("r_data", s_axi_rdata, e.data);
          chk("r_resp", s_axi_rresp, e.resp);
          chk("r_last", s_axi_rlast, e.last);
          chk("r_id", s_axi_rid, e.id);
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        last_bresp = s_axi_bresp;
        if (exp_b.size() == 0) chk("b_unexpected", s_axi_bresp, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          eb = exp_b.pop_front();
          chk("b_resp", s_axi_bresp, eb.resp);
          chk("b_id", s_axi_bid, eb.id);
        end
      end
      p_rv = s_axi_rvalid; p_rr = s_axi_rready; p_rdata = s_axi_rdata;
      p_rlast = s_axi_rlast; p_rresp = s_axi_rresp;
      p_mrv = mem_read_valid; p_mrr = mem_read_ready; p_mra = mem_read_address;
      p_mwv = mem_write_valid; p_mwr = mem_write_ready; p_mwa = mem_write_address;
      p_mwd = mem_write_data;
      p_bv = s_axi_bvalid; p_br = s_axi_bready; p_bresp = s_axi_bresp;
    end
  end

  // ---------------- drivers ----------------
  task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic id);
    int n;
    logic err;
    logic [31:0] w;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = sz; s_axi_arburst = bu;
    s_axi_arid = id; s_axi_arvalid = 1'b1;
    n = 0;
    #1;
    while (!s_axi_arready && n < 400) begin @(negedge clk); #1; n++; end
    if (!s_axi_arready) begin
      tfail("ar_grant");
      s_axi_arvalid = 1'b0;
      return;
    end
    err = (sz != 3'd2) || bu[1];
    for (int i = 0; i <= int'(len); i++) begin
      w = (a >> 2) + ((bu == 2'b01) ? 32'(i) : 32'd0);
      if (!err) exp_ra.push_back(w);
      exp_r.push_back('{data: err ? 32'd0 : mem_rd(w), resp: err ? 2'b10 : 2'b00,
                        last: (i == int'(len)), id: id});
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 600) begin @(negedge clk); #3; n++; end
    if (exp_r.size() != 0) begin tfail("r_complete"); exp_r.delete(); exp_ra.delete(); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic id);
    issue_ar(a, len, sz, bu, id);
    wait_r();
  endtask

  // Burst payload comes from tx_wd/tx_ws/tx_wl.
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic id);
    int n;
    logic err, wl_err;
    logic [31:0] w;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awsize = sz; s_axi_awburst = bu;
    s_axi_awid = id; s_axi_awvalid = 1'b1;
    n = 0;
    #1;
    while (!s_axi_awready && n < 400) begin @(negedge clk); #1; n++; end
    if (!s_axi_awready) begin
      tfail("aw_grant");
      s_axi_awvalid = 1'b0;
      return;
    end
    err = (sz != 3'd2) || bu[1];
    wl_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w = (a >> 2) + ((bu == 2'b01) ? 32'(i) : 32'd0);
      if (tx_wl[i] != (i == int'(len))) wl_err = 1'b1;
      if (!err && tx_ws[i] != 4'd0) begin
        exp_wa.push_back(w);
        exp_wd.push_back(tx_wd[i]);
      end
    end
    exp_b.push_back('{resp: (err || wl_err) ? 2'b10 : 2'b00, id: id});
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 2) == 0) begin s_axi_wvalid = 1'b0; @(negedge clk); end
      s_axi_wvalid = 1'b1; s_axi_wdata = tx_wd[i]; s_axi_wstrb = tx_ws[i]; s_axi_wlast = tx_wl[i];
      n = 0;
      #1;
      while (!s_axi_wready && n < 200) begin @(negedge clk); #1; n++; end
      if (!s_axi_wready) begin tfail("w_accept"); s_axi_wvalid = 1'b0; return; end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0;
    n = 0;
    while (exp_b.size() != 0 && n < 200) begin @(negedge clk); #3; n++; end
    if (exp_b.size() != 0) begin tfail("b_complete"); exp_b.delete(); end
  endtask

  task automatic set_burst(input int len, input logic [31:0] base, input logic bad_last);
    for (int i = 0; i <= len; i++) begin
      tx_wd[i] = base + 32'(i);
      tx_ws[i] = 4'hF;
      tx_wl[i] = (i == len) ^ (bad_last && i == 1);
    end
  endtask

  task automatic clear_logs();
    glog.delete(); rdlog.delete(); wlog_a.delete(); wlog_d.delete();
    rlog_d.delete(); rlog_resp.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, {s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
        s_axi_arready, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        mem_read_valid, mem_write_valid}, 64'd0);
    chk({tag, "_rdata"}, s_axi_rdata, 64'd0);
    chk({tag, "_mem_addr"}, {mem_read_address, mem_write_address}, 64'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] snap_d;
    logic snap_l;
    int len;
    reset = 1'b1;
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    s_axi_arvalid = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // simultaneous requests straight after reset: R first, then alternation
    clear_logs();
    rr_mode = 1; rd_delay = 1; wr_delay = 1;
    fork
      begin
        do_read(32'h40, 8'd1, 3'd2, 2'b01, 1'b0);
        do_read(32'h48, 8'd0, 3'd2, 2'b01, 1'b1);
      end
      begin
        set_burst(1, 32'hA0, 1'b0);
        do_write(32'h80, 8'd1, 3'd2, 2'b01, 1'b1);
        set_burst(0, 32'hB0, 1'b0);
        do_write(32'h90, 8'd0, 3'd2, 2'b01, 1'b0);
      end
    join
    chk("arb_count", glog.size(), 4);
    if (glog.size() == 4) chk("arb_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);

    // single zero-wait read
    clear_logs();
    mem_arr[32'd4] = 32'hDEAD_BEEF;
    rd_delay = 0;
    do_read(32'h10, 8'd0, 3'd2, 2'b01, 1'b1);
    chk("single_mem_addr", rdlog.size() == 1 ? rdlog[0] : 32'hFFFF_FFFF, 32'd4);
    chk("single_rdata", rlog_d.size() == 1 ? rlog_d[0] : 32'h0, 32'hDEAD_BEEF);
    chk("single_lat_mrv", t_mrv - t_ar, 1);
    chk("single_lat_rv", t_rv - t_ar, 2);

    // INCR write burst with a slow memory, then read it back
    clear_logs();
    wr_delay = 2;
    for (int i = 0; i < 4; i++) begin tx_wd[i] = 32'(i + 1); tx_ws[i] = 4'hF; tx_wl[i] = (i == 3); end
    do_write(32'h20, 8'd3, 3'd2, 2'b01, 1'b0);
    chk("wburst_count", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      chk("wburst_addrs", {wlog_a[0][7:0], wlog_a[1][7:0], wlog_a[2][7:0], wlog_a[3][7:0]}, 32'h08090A0B);
      chk("wburst_data", {wlog_d[0][7:0], wlog_d[1][7:0], wlog_d[2][7:0], wlog_d[3][7:0]}, 32'h01020304);
    end
    chk("wburst_bresp", last_bresp, 2'b00);
    do_read(32'h20, 8'd3, 3'd2, 2'b01, 1'b0);

    // bad size: no memory traffic, SLVERR beats with zero data
    clear_logs();
    do_read(32'h30, 8'd3, 3'd1, 2'b01, 1'b1);
    chk("err_no_mem", rdlog.size(), 0);
    chk("err_beats", rlog_resp.size(), 4);
    if (rlog_resp.size() == 4) chk("err_resp_data", {rlog_resp[3], rlog_d[3]}, {2'b10, 32'd0});

    // FIXED burst: three reads of the same word
    clear_logs();
    do_read(32'h44, 8'd2, 3'd2, 2'b00, 1'b0);
    chk("fixed_count", rdlog.size(), 3);
    if (rdlog.size() == 3) chk("fixed_addrs", {rdlog[0][7:0], rdlog[1][7:0], rdlog[2][7:0]}, 24'h111111);

    // early wlast: all writes still happen, SLVERR response
    clear_logs();
    wr_delay = 0;
    set_burst(2, 32'h70, 1'b1);
    do_write(32'h60, 8'd2, 3'd2, 2'b01, 1'b1);
    chk("wlast_writes", wlog_a.size(), 3);
    chk("wlast_bresp", last_bresp, 2'b10);

    // read-data backpressure
    rr_mode = 2;
    fork
      do_read(32'h10, 8'd1, 3'd2, 2'b01, 1'b0);
    join_none
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); #2; n++; end
    if (!s_axi_rvalid) tfail("bp_rvalid");
    else begin
      snap_d = s_axi_rdata;
      snap_l = s_axi_rlast;
      chk("bp_first_data", snap_d, 32'hDEAD_BEEF);
      repeat (5) begin
        @(negedge clk); #2;
        chk("bp_stable", {s_axi_rvalid, s_axi_rlast, s_axi_rdata}, {1'b1, snap_l, snap_d});
      end
    end
    rr_mode = 1;
    wait fork;

    // reset while a memory read is outstanding
    rd_delay = 20;
    issue_ar(32'h50, 8'd0, 3'd2, 2'b01, 1'b1);
    n = 0;
    while (!mem_read_valid && n < 50) begin @(negedge clk); #2; n++; end
    if (!mem_read_valid) tfail("rst_rd_mem");
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    exp_r.delete(); exp_ra.delete();
    @(negedge clk);
    reset = 1'b0;
    rd_delay = 0;
    clear_logs();
    do_read(32'h50, 8'd0, 3'd2, 2'b01, 1'b1);
    chk("post_reset_addr", rdlog.size() == 1 ? rdlog[0] : 32'hFFFF_FFFF, 32'h14);

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [2:0] sz;
      logic [1:0] bu;
      int r;
      rd_delay = $urandom_range(0, 2);
      wr_delay = $urandom_range(0, 2);
      rr_mode = $urandom_range(0, 1);
      len = $urandom_range(0, 4);
      a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      r = $urandom_range(0, 9);
      bu = (r < 2) ? 2'b00 : (r == 2) ? 2'($urandom_range(2, 3)) : 2'b01;
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, 8'(len), sz, bu, 1'($urandom_range(0, 1)));
      end else begin
        for (int i = 0; i <= len; i++) begin
          tx_wd[i] = $urandom;
          tx_ws[i] = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          tx_wl[i] = (i == len) ^ ($urandom_range(0, 9) == 0);
        end
        do_write(a, 8'(len), sz, bu, 1'($urandom_range(0, 1)));
      end
    end
    rr_mode = 1;
    repeat (4) @(negedge clk);
    chk("queues_drained", exp_r.size() + exp_ra.size() + exp_wa.size() + exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
